dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory access slot between two requesters.
  - CPU execute stage (port c): ld/st/ldp/stp.
  - Debug/loader requester (port d).
- Sits between those requesters and the memory's data read port (raddr1/rdata1) and write port. Replaces the ad-hoc stall bit chains with an explicit FSM.
- Issues one memory beat per cycle. Pair ops issue two consecutive locked beats.
- Returns read data tagged to the originating requester after a fixed latency.

Parameters:
- RD_LAT, 2: cycles from read-beat issue (mem_raddr driven) to mem_rdata valid; legal 1..4.
- STARVE_MAX, 8: consecutive cycles d_req may wait before debug is forced to win; legal 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  CPU request; held stable until c_gnt.
- c_we  in  1  1=write, 0=read.
- c_pair  in  1  two-word op at c_addr and c_addr+1.
- c_addr  in  15  word address [15:1].
- c_wdata0  in  16  write data, beat 0.
- c_wdata1  in  16  write data, beat 1 (pair only).
- c_gnt  out  1  combinational accept; beat 0 issues this cycle.
- c_rvalid  out  1  read beat returned to CPU.
- c_rlast  out  1  final beat of the op.
- c_rdata  out  16  read data.
- d_req, d_we, d_pair, d_addr, d_wdata0, d_wdata1, d_gnt, d_rvalid, d_rlast, d_rdata: same as the c_ group, for the debug port.
- mem_raddr  out  15  memory read address.
- mem_rdata  in  16  memory read data.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  15  memory write address.
- mem_wdata  out  16  memory write data.
- busy  out  1  1 while in BEAT2 or any read tag in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM=IDLE.
  - All tag pipeline valids 0.
  - Starvation counter 0.
  - mem_raddr/mem_waddr 0.
  - All gnt, rvalid, rlast, mem_wen and busy outputs 0.
  - rdata outputs 0.
- FSM IDLE, arbitration when at least one req:
  - Winner = CPU, unless d_req && starve_cnt==STARVE_MAX, in which case winner = debug.
  - Winner's gnt=1 this cycle, combinational from req and state.
  - Beat 0 issues this cycle at addr.
  - If the winner's pair=1: latch winner, addr+1 and wdata1; next state BEAT2.
- FSM BEAT2:
  - Issues the latched beat 1. No gnt to either port.
  - Next state IDLE, so a new grant is possible in the following cycle.
- Beat issue:
  - Write beat: mem_wen=1, mem_waddr=addr, mem_wdata=wdata for that beat.
  - Read beat: mem_raddr=addr.
  - No beat: mem_wen=0 and mem_raddr holds its last value.
  - A read and a write never issue in the same cycle.
- Starvation counter:
  - Increments each cycle d_req=1 and d_gnt=0, saturating at STARVE_MAX.
  - Clears on d_gnt or when d_req=0.
- Read return:
  - Each read beat pushes tag {valid, id, last} into an RD_LAT-deep shift register.
  - On tag exit, that port's rvalid=1, rdata=mem_rdata, rlast=last. Registered outputs are aligned to mem_rdata.
  - Writes push nothing.
  - For single ops last=1. For pairs, last=1 on beat 1 only.
- Address arithmetic: beat-1 address = addr+1 mod 2^15, so 15'h7FFF wraps to 15'h0000.
- Simultaneous events:
  - Both req in IDLE with no starvation: CPU wins; debug waits and its counter increments.
  - A new req arriving during BEAT2 waits.
  - Read tags from both ports may be in flight concurrently; order is preserved.
- rst_n asserted mid-operation:
  - BEAT2 is abandoned and tags are flushed.
  - No rvalid is produced for pre-reset beats.
  - No write beat issues after reset assertion.

Decomposition:
- Shared package holds:
  - State enum IDLE/BEAT2.
  - Requester id constants REQ_CPU=0, REQ_DBG=1.
  - Tag struct {valid, id, last}.
- One sub-module: dmem_rtag_pipe, the parameterised RD_LAT-deep tag/return shift register with async clear.

Test Plan:
- CPU read at 0x0010, RD_LAT=2 -> c_gnt same cycle, mem_raddr=0x0010, c_rvalid=1 and c_rlast=1 two cycles later with c_rdata=mem[0x0010].
- CPU pair write, addr 0x7FFF, wdata0=0xAAAA, wdata1=0x5555 -> mem_wen two consecutive cycles at 0x7FFF then 0x0000; no gnt in cycle 2; busy=1 in cycle 2.
- c_req and d_req held continuously, STARVE_MAX=3 -> CPU granted 3 cycles, then d_gnt on cycle 4, counter cleared, CPU granted again on cycle 5.
- CPU pair read at 0x0100 followed immediately by debug read at 0x0200 -> returns c(0x0100, rlast=0), c(0x0101, rlast=1), d(0x0200, rlast=1) on consecutive cycles.
- Debug pair read granted, rst_n pulsed low during BEAT2 -> no d_rvalid ever appears, outputs 0, busy=0, next request is granted normally after release.
- d_req only, d_we=1, addr 0x0042, wdata0=0x1234 -> d_gnt same cycle, mem_wen=1, mem_waddr=0x0042, mem_wdata=0x1234, no rvalid.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and
// the read-return tag carried through the latency pipeline.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic last;
  } rtag_t;

  // Beat-1 address of a pair op; wraps 15'h7FFF to 15'h0000.
  function automatic logic [14:0] next_addr(input logic [14:0] addr);
    return addr + 15'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's connection to the arbiter: request fields toward the
// arbiter, grant and tagged read return back to the requester.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic        pair;
  logic [14:0] addr;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt;
  logic        rvalid;
  logic        rlast;
  logic [15:0] rdata;

  modport master (output req, we, pair, addr, wdata0, wdata1,
                  input  gnt, rvalid, rlast, rdata);
  modport slave  (input  req, we, pair, addr, wdata0, wdata1,
                  output gnt, rvalid, rlast, rdata);
endinterface

// File: rtl/dmem_arbiter_rtag_pipe.sv
// Read-return tag shift register: one tag per read beat, emerging exactly
// RD_LAT cycles later alongside the memory's read data.
module dmem_rtag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  rtag_t push_i,
  output rtag_t exit_o,
  output logic  busy_o
);

  rtag_t stage_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign exit_o = stage_q[RD_LAT-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < RD_LAT; i++) busy_o = busy_o | stage_q[i].valid;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory slot arbiter between the CPU execute stage (c) and the
// debug/loader port (d); pair ops take two locked consecutive beats.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave d,
  output logic [14:0]   mem_raddr,
  input  logic [15:0]   mem_rdata,
  output logic          mem_wen,
  output logic [14:0]   mem_waddr,
  output logic [15:0]   mem_wdata,
  output logic          busy
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        b2_id_q, b2_we_q;
  logic [14:0] b2_addr_q;
  logic [15:0] b2_wdata_q;
  logic [14:0] raddr_q, waddr_q;

  logic        c_win, d_win, any_win;
  logic        win_id, win_we, win_pair;
  logic [14:0] win_addr;
  logic [15:0] win_wdata0, win_wdata1;
  logic        beat_vld, beat_we, beat_id, beat_last;
  logic [14:0] beat_addr;
  logic [15:0] beat_wdata;
  rtag_t       tag_push, tag_exit;
  logic        tags_busy;

  // Grants are suppressed while reset is held so nothing issues mid-reset.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (rst_n && state_q == IDLE) begin
      d_win = d.req && ((starve_q == STARVE_LIM) || !c.req);
      c_win = c.req && !d_win;
    end
  end

  assign any_win = c_win || d_win;
  assign c.gnt   = c_win;
  assign d.gnt   = d_win;

  always_comb begin
    win_id     = d_win ? REQ_DBG  : REQ_CPU;
    win_we     = d_win ? d.we     : c.we;
    win_pair   = d_win ? d.pair   : c.pair;
    win_addr   = d_win ? d.addr   : c.addr;
    win_wdata0 = d_win ? d.wdata0 : c.wdata0;
    win_wdata1 = d_win ? d.wdata1 : c.wdata1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_win && win_pair) state_d = BEAT2;
      BEAT2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_vld   = 1'b0;
    beat_we    = b2_we_q;
    beat_id    = b2_id_q;
    beat_last  = 1'b1;
    beat_addr  = b2_addr_q;
    beat_wdata = b2_wdata_q;
    case (state_q)
      IDLE: begin
        if (any_win) begin
          beat_vld   = 1'b1;
          beat_we    = win_we;
          beat_id    = win_id;
          beat_last  = !win_pair;
          beat_addr  = win_addr;
          beat_wdata = win_wdata0;
        end
      end
      BEAT2:   beat_vld = rst_n;
      default: beat_vld = 1'b0;
    endcase
  end

  // Idle cycles keep the last addresses on the memory buses.
  assign mem_wen   = beat_vld && beat_we;
  assign mem_wdata = mem_wen ? beat_wdata : '0;
  assign mem_waddr = mem_wen ? beat_addr : waddr_q;
  assign mem_raddr = (beat_vld && !beat_we) ? beat_addr : raddr_q;

  always_comb begin
    starve_d = '0;
    if (d.req && !d_win)
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      b2_id_q    <= REQ_CPU;
      b2_we_q    <= 1'b0;
      b2_addr_q  <= '0;
      b2_wdata_q <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
    end else begin
      starve_q <= starve_d;
      raddr_q  <= mem_raddr;
      waddr_q  <= mem_waddr;
      if (state_q == IDLE && any_win && win_pair) begin
        b2_id_q    <= win_id;
        b2_we_q    <= win_we;
        b2_addr_q  <= next_addr(win_addr);
        b2_wdata_q <= win_wdata1;
      end
    end
  end

  always_comb begin
    tag_push       = '0;
    tag_push.valid = beat_vld && !beat_we;
    tag_push.id    = beat_id;
    tag_push.last  = beat_last;
  end

  dmem_rtag_pipe #(.RD_LAT(RD_LAT)) u_rtag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (tag_push),
    .exit_o (tag_exit),
    .busy_o (tags_busy)
  );

  assign c.rvalid = tag_exit.valid && (tag_exit.id == REQ_CPU);
  assign c.rlast  = c.rvalid && tag_exit.last;
  assign c.rdata  = c.rvalid ? mem_rdata : '0;
  assign d.rvalid = tag_exit.valid && (tag_exit.id == REQ_DBG);
  assign d.rlast  = d.rvalid && tag_exit.last;
  assign d.rdata  = d.rvalid ? mem_rdata : '0;

  assign busy = (state_q == BEAT2) || tags_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grants, beats and read returns.
module tb_dmem_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 3;

  typedef struct {
    int          due;
    bit          port;
    logic [14:0] addr;
    bit          last;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] mem_raddr, mem_waddr;
  logic [15:0] mem_rdata, mem_wdata;
  logic        mem_wen, busy;
  logic [15:0] sim_mem [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [14:0] rd_dly  [RD_LAT];
  int          vectors = 0;
  int          miscompares = 0;

  dmem_arbiter_if c_if();
  dmem_arbiter_if d_if();

  dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c_if),
    .d         (d_if),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory with RD_LAT cycles from raddr to rdata; writes land on the edge.
  always @(posedge clk) begin
    if (mem_wen) sim_mem[mem_waddr] <= mem_wdata;
    rd_dly[0] <= mem_raddr;
    for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end
  assign mem_rdata = sim_mem[rd_dly[RD_LAT-1]];

  function automatic logic [15:0] seed_val(input int a);
    return 16'((a * 40503) ^ 16'h1D2B);
  endfunction

  function automatic logic [14:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 15'h7FFF;
    return 15'($urandom_range(0, 31));
  endfunction

  task automatic applyStimulus(input bit port, input bit we, input bit pair,
                               input logic [14:0] addr, input logic [15:0] w0,
                               input logic [15:0] w1);
    if (port) begin
      d_if.req = 1'b1; d_if.we = we; d_if.pair = pair;
      d_if.addr = addr; d_if.wdata0 = w0; d_if.wdata1 = w1;
    end else begin
      c_if.req = 1'b1; c_if.we = we; c_if.pair = pair;
      c_if.addr = addr; c_if.wdata0 = w0; c_if.wdata1 = w1;
    end
  endtask

  task automatic releaseReq(input bit port);
    if (port) d_if.req = 1'b0;
    else      c_if.req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h0005, 16'hBEEF, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0006, 16'h0000, 16'h0000);
    #13;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL reset_gnt: got %b want 00", {c_if.gnt, d_if.gnt});
    end
    vectors++;
    if (mem_wen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_wen: got %b want 0", mem_wen);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (mem_raddr !== 15'h0 || mem_waddr !== 15'h0) begin
      miscompares++; $display("[TB] FAIL reset_addr: got %h/%h want 0/0", mem_raddr, mem_waddr);
    end
    vectors++;
    if ({c_if.rvalid, c_if.rlast, d_if.rvalid, d_if.rlast} !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset_rvalid: got %b want 0000",
                              {c_if.rvalid, c_if.rlast, d_if.rvalid, d_if.rlast});
    end
    vectors++;
    if (c_if.rdata !== 16'h0 || d_if.rdata !== 16'h0) begin
      miscompares++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", c_if.rdata, d_if.rdata);
    end
    releaseReq(1'b0);
    releaseReq(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 15'h0010, 16'h0, 16'h0);
    #2;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL cpu_rd_gnt: got %b want 10", {c_if.gnt, d_if.gnt});
    end
    vectors++;
    if (mem_raddr !== 15'h0010 || mem_wen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cpu_rd_issue: got raddr %h wen %b want 0010 0", mem_raddr, mem_wen);
    end
    @(negedge clk);
    releaseReq(1'b0);
    #2;
    vectors++;
    if (c_if.rvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cpu_rd_early: got rvalid %b want 0", c_if.rvalid);
    end
    @(negedge clk);
    #2;
    vectors++;
    if ({c_if.rvalid, c_if.rlast} !== 2'b11 || c_if.rdata !== ref_mem[15'h0010]) begin
      miscompares++; $display("[TB] FAIL cpu_rd_return: got %b %h want 11 %h",
                              {c_if.rvalid, c_if.rlast}, c_if.rdata, ref_mem[15'h0010]);
    end
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_debug_write();
    bit seen_rv;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0042, 16'h1234, 16'h0);
    #2;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b01) begin
      miscompares++; $display("[TB] FAIL dbg_wr_gnt: got %b want 01", {c_if.gnt, d_if.gnt});
    end
    vectors++;
    if (mem_wen !== 1'b1 || mem_waddr !== 15'h0042 || mem_wdata !== 16'h1234) begin
      miscompares++; $display("[TB] FAIL dbg_wr_beat: got %b %h %h want 1 0042 1234",
                              mem_wen, mem_waddr, mem_wdata);
    end
    ref_mem[15'h0042] = 16'h1234;
    seen_rv = 1'b0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge clk);
      releaseReq(1'b1);
      #2;
      seen_rv = seen_rv | c_if.rvalid | d_if.rvalid;
    end
    vectors++;
    if (seen_rv !== 1'b0) begin
      miscompares++; $display("[TB] FAIL dbg_wr_no_rvalid: got %b want 0", seen_rv);
    end
  endtask

  task automatic test_pair_write_wrap();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 15'h7FFF, 16'hAAAA, 16'h5555);
    #2;
    vectors++;
    if (c_if.gnt !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 15'h7FFF || mem_wdata !== 16'hAAAA) begin
      miscompares++; $display("[TB] FAIL pair_wr_beat0: got gnt %b %b %h %h want 1 1 7fff aaaa",
                              c_if.gnt, mem_wen, mem_waddr, mem_wdata);
    end
    @(negedge clk);
    releaseReq(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0300, 16'h0, 16'h0);
    #2;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b00 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pair_wr_lock: got gnt %b busy %b want 00 1",
                              {c_if.gnt, d_if.gnt}, busy);
    end
    vectors++;
    if (mem_wen !== 1'b1 || mem_waddr !== 15'h0000 || mem_wdata !== 16'h5555) begin
      miscompares++; $display("[TB] FAIL pair_wr_beat1: got %b %h %h want 1 0000 5555",
                              mem_wen, mem_waddr, mem_wdata);
    end
    ref_mem[15'h7FFF] = 16'hAAAA;
    ref_mem[15'h0000] = 16'h5555;
    @(negedge clk);
    #2;
    vectors++;
    if (d_if.gnt !== 1'b1 || mem_raddr !== 15'h0300 || mem_wen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pair_wr_next_gnt: got %b %h %b want 1 0300 0",
                              d_if.gnt, mem_raddr, mem_wen);
    end
    @(negedge clk);
    releaseReq(1'b1);
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 15'h0020, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0030, 16'h0, 16'h0);
    for (int k = 1; k <= STARVE_MAX + 2; k++) begin
      #2;
      want = (k == STARVE_MAX + 1) ? 2'b01 : 2'b10;
      vectors++;
      if ({c_if.gnt, d_if.gnt} !== want) begin
        miscompares++; $display("[TB] FAIL starve_cycle%0d: got %b want %b", k, {c_if.gnt, d_if.gnt}, want);
      end
      if (k == STARVE_MAX + 1) begin
        vectors++;
        if (mem_raddr !== 15'h0030) begin
          miscompares++; $display("[TB] FAIL starve_dbg_addr: got %h want 0030", mem_raddr);
        end
      end
      @(negedge clk);
    end
    releaseReq(1'b0);
    releaseReq(1'b1);
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_pair_then_debug();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 15'h0100, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0200, 16'h0, 16'h0);
    #2;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b10 || mem_raddr !== 15'h0100) begin
      miscompares++; $display("[TB] FAIL pd_c1: got %b %h want 10 0100", {c_if.gnt, d_if.gnt}, mem_raddr);
    end
    @(negedge clk);
    releaseReq(1'b0);
    #2;
    vectors++;
    if ({c_if.gnt, d_if.gnt} !== 2'b00 || mem_raddr !== 15'h0101 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pd_c2: got %b %h %b want 00 0101 1",
                              {c_if.gnt, d_if.gnt}, mem_raddr, busy);
    end
    @(negedge clk);
    #2;
    vectors++;
    if (d_if.gnt !== 1'b1 || mem_raddr !== 15'h0200) begin
      miscompares++; $display("[TB] FAIL pd_c3_gnt: got %b %h want 1 0200", d_if.gnt, mem_raddr);
    end
    vectors++;
    if ({c_if.rvalid, c_if.rlast} !== 2'b10 || c_if.rdata !== ref_mem[15'h0100]) begin
      miscompares++; $display("[TB] FAIL pd_ret0: got %b %h want 10 %h",
                              {c_if.rvalid, c_if.rlast}, c_if.rdata, ref_mem[15'h0100]);
    end
    @(negedge clk);
    releaseReq(1'b1);
    #2;
    vectors++;
    if ({c_if.rvalid, c_if.rlast, d_if.rvalid} !== 3'b110 || c_if.rdata !== ref_mem[15'h0101]) begin
      miscompares++; $display("[TB] FAIL pd_ret1: got %b %h want 110 %h",
                              {c_if.rvalid, c_if.rlast, d_if.rvalid}, c_if.rdata, ref_mem[15'h0101]);
    end
    @(negedge clk);
    #2;
    vectors++;
    if ({d_if.rvalid, d_if.rlast, c_if.rvalid} !== 3'b110 || d_if.rdata !== ref_mem[15'h0200]) begin
      miscompares++; $display("[TB] FAIL pd_ret2: got %b %h want 110 %h",
                              {d_if.rvalid, d_if.rlast, c_if.rvalid}, d_if.rdata, ref_mem[15'h0200]);
    end
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_pair();
    bit seen_rv;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 15'h0400, 16'h0, 16'h0);
    #2;
    vectors++;
    if (d_if.gnt !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rstmid_gnt: got %b want 1", d_if.gnt);
    end
    @(negedge clk);
    releaseReq(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || mem_wen !== 1'b0 || d_if.rvalid !== 1'b0 || mem_raddr !== 15'h0) begin
      miscompares++; $display("[TB] FAIL rstmid_outputs: got busy %b wen %b rv %b raddr %h want 0 0 0 0",
                              busy, mem_wen, d_if.rvalid, mem_raddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_rv = 1'b0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      #2;
      seen_rv = seen_rv | d_if.rvalid | c_if.rvalid | busy;
      @(negedge clk);
    end
    vectors++;
    if (seen_rv !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_flushed: got %b want 0", seen_rv);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0, 16'h0);
    #2;
    vectors++;
    if (d_if.gnt !== 1'b1 || mem_raddr !== 15'h0010) begin
      miscompares++; $display("[TB] FAIL rstmid_regrant: got %b %h want 1 0010", d_if.gnt, mem_raddr);
    end
    @(negedge clk);
    releaseReq(1'b1);
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  // Model: each cycle one beat at most; pending second beats win over any
  // request, debug wins when it has waited STARVE_MAX cycles or CPU is idle.
  task automatic test_random();
    ret_t        rq[$];
    bit          m_b2, b2_port, b2_we, c_took, d_took;
    logic [14:0] b2_addr;
    logic [15:0] b2_wdata;
    int          wait_cnt;
    m_b2 = 1'b0; c_took = 1'b0; d_took = 1'b0; wait_cnt = 0;
    b2_port = 1'b0; b2_we = 1'b0; b2_addr = '0; b2_wdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit          exp_c, exp_d, hb, bp, bwe, blast, pair, exp_busy, ec, ed;
      logic [14:0] ba;
      logic [15:0] bwd, w1, edata;
      bit          elast;
      @(negedge clk);
      if (c_took) releaseReq(1'b0);
      if (d_took) releaseReq(1'b1);
      if (!c_if.req && $urandom_range(0, 2) != 0)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      rand_addr(), 16'($urandom), 16'($urandom));
      if (!d_if.req && $urandom_range(0, 2) == 0)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      rand_addr(), 16'($urandom), 16'($urandom));
      #2;
      exp_busy = m_b2;
      foreach (rq[i]) if (rq[i].due >= cyc && rq[i].due - RD_LAT < cyc) exp_busy = 1'b1;
      exp_c = 1'b0; exp_d = 1'b0; hb = 1'b0; bp = 1'b0; bwe = 1'b0;
      blast = 1'b1; pair = 1'b0; ba = '0; bwd = '0; w1 = '0;
      if (m_b2) begin
        hb = 1'b1; bp = b2_port; bwe = b2_we; ba = b2_addr; bwd = b2_wdata;
        m_b2 = 1'b0;
      end else if (c_if.req || d_if.req) begin
        hb = 1'b1;
        if (d_if.req && (wait_cnt == STARVE_MAX || !c_if.req)) begin
          exp_d = 1'b1; bp = 1'b1; bwe = d_if.we; pair = d_if.pair;
          ba = d_if.addr; bwd = d_if.wdata0; w1 = d_if.wdata1;
        end else begin
          exp_c = 1'b1; bp = 1'b0; bwe = c_if.we; pair = c_if.pair;
          ba = c_if.addr; bwd = c_if.wdata0; w1 = c_if.wdata1;
        end
        blast = !pair;
        if (pair) begin
          m_b2 = 1'b1; b2_port = bp; b2_we = bwe; b2_addr = 15'(ba + 15'd1); b2_wdata = w1;
        end
      end
      vectors++;
      if ({c_if.gnt, d_if.gnt} !== {exp_c, exp_d}) begin
        miscompares++; $display("[TB] FAIL rnd_gnt cyc%0d: got %b want %b", cyc, {c_if.gnt, d_if.gnt}, {exp_c, exp_d});
      end
      vectors++;
      if (mem_wen !== (hb && bwe)) begin
        miscompares++; $display("[TB] FAIL rnd_wen cyc%0d: got %b want %b", cyc, mem_wen, hb && bwe);
      end
      if (hb && bwe) begin
        vectors++;
        if (mem_waddr !== ba || mem_wdata !== bwd) begin
          miscompares++; $display("[TB] FAIL rnd_wr cyc%0d: got %h %h want %h %h", cyc, mem_waddr, mem_wdata, ba, bwd);
        end
      end
      if (hb && !bwe) begin
        vectors++;
        if (mem_raddr !== ba) begin
          miscompares++; $display("[TB] FAIL rnd_raddr cyc%0d: got %h want %h", cyc, mem_raddr, ba);
        end
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++; $display("[TB] FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, exp_busy);
      end
      ec = 1'b0; ed = 1'b0; edata = '0; elast = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ec = !rq[0].port; ed = rq[0].port; edata = ref_mem[rq[0].addr]; elast = rq[0].last;
        void'(rq.pop_front());
      end
      vectors++;
      if ({c_if.rvalid, d_if.rvalid} !== {ec, ed}) begin
        miscompares++; $display("[TB] FAIL rnd_rvalid cyc%0d: got %b want %b", cyc, {c_if.rvalid, d_if.rvalid}, {ec, ed});
      end
      if (ec || ed) begin
        vectors++;
        if ((ec ? c_if.rdata : d_if.rdata) !== edata || (ec ? c_if.rlast : d_if.rlast) !== elast) begin
          miscompares++; $display("[TB] FAIL rnd_rdata cyc%0d: got %h last %b want %h last %b", cyc,
                                  ec ? c_if.rdata : d_if.rdata, ec ? c_if.rlast : d_if.rlast, edata, elast);
        end
      end
      if (hb && !bwe) rq.push_back('{due: cyc + RD_LAT, port: bp, addr: ba, last: blast});
      if (hb && bwe) ref_mem[ba] = bwd;
      if (d_if.req && !exp_d) wait_cnt = (wait_cnt == STARVE_MAX) ? STARVE_MAX : wait_cnt + 1;
      else                    wait_cnt = 0;
      c_took = exp_c;
      d_took = exp_d;
    end
    @(negedge clk);
    releaseReq(1'b0);
    releaseReq(1'b1);
    repeat (RD_LAT + 3) @(negedge clk);
  endtask

  initial begin
    c_if.req = 1'b0; c_if.we = 1'b0; c_if.pair = 1'b0;
    c_if.addr = '0; c_if.wdata0 = '0; c_if.wdata1 = '0;
    d_if.req = 1'b0; d_if.we = 1'b0; d_if.pair = 1'b0;
    d_if.addr = '0; d_if.wdata0 = '0; d_if.wdata1 = '0;
    for (int i = 0; i < RD_LAT; i++) rd_dly[i] = '0;
    for (int a = 0; a < 32768; a++) begin
      sim_mem[a] = seed_val(a);
      ref_mem[a] = seed_val(a);
    end
    test_reset();
    test_cpu_read();
    test_debug_write();
    test_pair_write_wrap();
    test_starvation();
    test_pair_then_debug();
    test_reset_mid_pair();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
